// File: rtl/or1200_aes_arb_pkg.sv
// Shared constants for the OR1200 AES pad arbiter: FSM encodings and the
// default abort limit for an AES operation.
package or1200_aes_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [7:0] AES_ARB_TIMEOUT = 8'd63;

endpackage

// File: rtl/or1200_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
// After reset requester 1 counts as last winner, so requester 0 goes first.
module or1200_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic update_i,
    output logic valid_o,
    output logic gnt_o
);

    logic last_q;
    logic gnt_d;

    always_comb begin
        gnt_d = 1'b0;
        if (req0_i && req1_i) begin
            gnt_d = ~last_q;
        end else if (req1_i) begin
            gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= gnt_d;
        end
    end

    assign valid_o = req0_i | req1_i;
    assign gnt_o   = gnt_d;

endmodule

// File: rtl/or1200_aes_arbiter.sv
// Shares one AES core between the load and store pad requesters, with
// per-requester OFB chaining and a bounded wait for the core to finish.
module or1200_aes_arbiter
    import or1200_aes_arb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = AES_ARB_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] seed0,
    input  logic [127:0] seed1,
    input  logic         chain0,
    input  logic         chain1,
    output logic         ack0,
    output logic         ack1,
    output logic [127:0] pad_out,
    output logic         err,
    output logic         aes_ld,
    output logic [127:0] aes_text_in,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out,
    output logic         busy
);

    logic [1:0]   state_q, state_d;
    logic         gnt_q;
    logic         err_q;
    logic [7:0]   cnt_q;
    logic [127:0] text_q;
    logic [127:0] pad_q;
    logic [127:0] chain0_q;
    logic [127:0] chain1_q;

    logic arb_valid;
    logic arb_gnt;
    logic start;
    logic timed_out;

    or1200_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0_i   (req0),
        .req1_i   (req1),
        .update_i (start),
        .valid_o  (arb_valid),
        .gnt_o    (arb_gnt)
    );

    assign start     = (state_q == ST_IDLE) && key_valid && arb_valid;
    assign timed_out = !aes_done && (cnt_q == TIMEOUT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: if (aes_done || timed_out) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Inputs are captured only at grant, so requesters may change them freely
    // while their operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            text_q   <= '0;
            pad_q    <= '0;
            chain0_q <= '0;
            chain1_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        gnt_q  <= arb_gnt;
                        err_q  <= 1'b0;
                        text_q <= arb_gnt ? (chain1 ? chain1_q : seed1)
                                          : (chain0 ? chain0_q : seed0);
                    end
                end
                ST_LOAD: cnt_q <= 8'd0;
                ST_WAIT: begin
                    if (aes_done) begin
                        pad_q <= aes_text_out;
                        err_q <= 1'b0;
                        if (gnt_q) chain1_q <= aes_text_out;
                        else       chain0_q <= aes_text_out;
                    end else if (timed_out) begin
                        pad_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign aes_ld      = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign ack0        = (state_q == ST_RESP) && !gnt_q;
    assign ack1        = (state_q == ST_RESP) &&  gnt_q;
    assign err         = (state_q == ST_RESP) && err_q;
    assign pad_out     = pad_q;
    assign aes_text_in = text_q;

endmodule

// File: tb/tb_or1200_aes_arbiter.sv
// Directed bench for or1200_aes_arbiter with a behavioural AES core that
// answers a programmable number of cycles after each start pulse.
module tb_or1200_aes_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_valid = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [127:0] seed0 = '0;
   logic [127:0] seed1 = '0;
   logic         chain0 = 1'b0;
   logic         chain1 = 1'b0;
   logic         ack0, ack1, err, aes_ld, busy;
   logic [127:0] pad_out, aes_text_in;
   logic         aes_done = 1'b0;
   logic [127:0] aes_text_out = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   int           modelDelay = 11;
   logic         modelNever = 1'b0;
   logic [127:0] modelOut = '0;
   int           modelCnt = 0;

   localparam logic [127:0] PAD_A5 = {16{8'hA5}};

   or1200_aes_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .req0         (req0),
      .req1         (req1),
      .seed0        (seed0),
      .seed1        (seed1),
      .chain0       (chain0),
      .chain1       (chain1),
      .ack0         (ack0),
      .ack1         (ack1),
      .pad_out      (pad_out),
      .err          (err),
      .aes_ld       (aes_ld),
      .aes_text_in  (aes_text_in),
      .aes_done     (aes_done),
      .aes_text_out (aes_text_out),
      .busy         (busy)
   );

   // Free-running clock and a cycle counter used to measure latencies.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // AES core model: done pulses modelDelay cycles after the cycle aes_ld is seen.
   initial begin
      forever begin
         @(negedge clk);
         aes_done = 1'b0;
         if (modelCnt > 0) begin
            modelCnt--;
            if (modelCnt == 0) begin
               aes_done = 1'b1;
               aes_text_out = modelOut;
            end
         end
         if (aes_ld && !modelNever) modelCnt = modelDelay;
      end
   end

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives all requester-side inputs at once.
   task automatic applyStimulus(input logic r0, input logic r1, input logic kv,
                                input logic c0, input logic c1,
                                input logic [127:0] s0, input logic [127:0] s1);
      req0 = r0;
      req1 = r1;
      key_valid = kv;
      chain0 = c0;
      chain1 = c1;
      seed0 = s0;
      seed1 = s1;
   endtask

   // Waits (bounded) for the AES start pulse and returns its cycle.
   task automatic waitLd(input string tag, output int ldCyc);
      logic found;
      found = 1'b0;
      ldCyc = -1;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (aes_ld) begin
            found = 1'b1;
            ldCyc = cyc;
         end
      end
      checkOutput({tag, " aes_ld seen"}, found, 1'b1);
   endtask

   // Waits (bounded) for an ack and returns which requester and the cycle.
   task automatic waitAck(input string tag, output int which, output int ackCyc);
      logic found;
      found = 1'b0;
      which = -1;
      ackCyc = -1;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            found = 1'b1;
            which = ack1 ? 1 : 0;
            ackCyc = cyc;
            checkOutput({tag, " single ack"}, ack0 & ack1, 1'b0);
         end
      end
      checkOutput({tag, " ack seen"}, found, 1'b1);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      int ldCyc, ackCyc, which, seenCnt;

      repeat (2) @(negedge clk);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset ack0", ack0, 1'b0);
      checkOutput("reset ack1", ack1, 1'b0);
      checkOutput("reset err", err, 1'b0);
      checkOutput("reset aes_ld", aes_ld, 1'b0);
      checkOutput("reset pad_out", pad_out, 128'h0);
      rst = 1'b0;

      modelDelay = 11;
      modelOut = PAD_A5;
      applyStimulus(1, 0, 1, 0, 0, 128'h1, 128'h0);
      waitLd("single", ldCyc);
      checkOutput("single text_in", aes_text_in, 128'h1);
      seed0 = 128'hDEAD;
      @(negedge clk);
      checkOutput("single text held", aes_text_in, 128'h1);
      checkOutput("single ld one cycle", aes_ld, 1'b0);
      waitAck("single", which, ackCyc);
      checkOutput("single who", which, 0);
      checkOutput("single latency", ackCyc - ldCyc, 12);
      checkOutput("single pad", pad_out, PAD_A5);
      checkOutput("single err", err, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("single ack0 once", ack0, 1'b0);
      checkOutput("single ack1 never", ack1, 1'b0);
      checkOutput("single idle", busy, 1'b0);
      checkOutput("single pad held", pad_out, PAD_A5);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelDelay = 2;
      modelOut = 128'h77;
      applyStimulus(1, 1, 1, 0, 0, 128'h10, 128'h11);
      for (int k = 0; k < 4; k++) begin
         waitAck("rr", which, ackCyc);
         checkOutput("rr order", which, k % 2);
         if (k == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         @(negedge clk);
         checkOutput("rr idle gap", busy, 1'b0);
         if (k < 3) begin
            @(negedge clk);
            checkOutput("rr regrant", aes_ld, 1'b1);
         end
      end

      modelOut = 128'hBEEF;
      applyStimulus(0, 1, 1, 0, 0, 128'h0, 128'h5);
      waitLd("seed1", ldCyc);
      checkOutput("seed1 text_in", aes_text_in, 128'h5);
      waitAck("seed1", which, ackCyc);
      checkOutput("seed1 who", which, 1);
      checkOutput("seed1 pad", pad_out, 128'hBEEF);
      req1 = 1'b0;
      @(negedge clk);
      modelOut = 128'h1234;
      applyStimulus(0, 1, 1, 0, 1, 128'h0, 128'h6);
      waitLd("chain1", ldCyc);
      checkOutput("chain1 text_in", aes_text_in, 128'hBEEF);
      waitAck("chain1", which, ackCyc);
      checkOutput("chain1 who", which, 1);
      checkOutput("chain1 pad", pad_out, 128'h1234);
      applyStimulus(0, 0, 1, 0, 0, 128'h0, 128'h0);
      @(negedge clk);

      modelOut = 128'hC0DE;
      applyStimulus(1, 0, 1, 1, 0, 128'h9, 128'h0);
      waitLd("drop", ldCyc);
      checkOutput("drop text_in", aes_text_in, 128'h77);
      req0 = 1'b0;
      waitAck("drop", which, ackCyc);
      checkOutput("drop who", which, 0);
      checkOutput("drop pad", pad_out, 128'hC0DE);
      @(negedge clk);

      modelNever = 1'b1;
      applyStimulus(1, 0, 1, 0, 0, 128'h42, 128'h0);
      waitLd("timeout", ldCyc);
      checkOutput("timeout text_in", aes_text_in, 128'h42);
      waitAck("timeout", which, ackCyc);
      checkOutput("timeout who", which, 0);
      checkOutput("timeout latency", ackCyc - ldCyc, 65);
      checkOutput("timeout err", err, 1'b1);
      checkOutput("timeout pad", pad_out, 128'h0);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("timeout err clears", err, 1'b0);
      modelNever = 1'b0;
      modelDelay = 3;
      modelOut = 128'h99;
      applyStimulus(1, 0, 1, 1, 0, 128'h0, 128'h0);
      waitLd("after timeout", ldCyc);
      checkOutput("after timeout chain kept", aes_text_in, 128'hC0DE);
      waitAck("after timeout", which, ackCyc);
      checkOutput("after timeout latency", ackCyc - ldCyc, 4);
      checkOutput("after timeout err", err, 1'b0);
      checkOutput("after timeout pad", pad_out, 128'h99);
      req0 = 1'b0;
      @(negedge clk);

      modelOut = 128'hAB;
      applyStimulus(1, 0, 0, 0, 0, 128'h3, 128'h0);
      seenCnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (aes_ld || busy) seenCnt++;
      end
      checkOutput("nokey no grant", seenCnt, 0);
      key_valid = 1'b1;
      @(negedge clk);
      checkOutput("key rise aes_ld", aes_ld, 1'b1);
      key_valid = 1'b0;
      waitAck("key drop", which, ackCyc);
      checkOutput("key drop who", which, 0);
      checkOutput("key drop pad", pad_out, 128'hAB);
      req0 = 1'b0;
      key_valid = 1'b1;
      @(negedge clk);

      modelDelay = 8;
      modelOut = 128'hEE;
      applyStimulus(1, 0, 1, 0, 0, 128'h4, 128'h0);
      waitLd("rst mid", ldCyc);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst mid idle", busy, 1'b0);
      seenCnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ack0 || ack1 || busy) seenCnt++;
      end
      checkOutput("rst mid no ack", seenCnt, 0);
      modelDelay = 2;
      applyStimulus(1, 0, 1, 1, 0, 128'hF0, 128'h0);
      waitLd("rst chain0", ldCyc);
      checkOutput("rst chain0 zero", aes_text_in, 128'h0);
      waitAck("rst chain0", which, ackCyc);
      req0 = 1'b0;
      @(negedge clk);
      applyStimulus(0, 1, 1, 0, 1, 128'h0, 128'hF1);
      waitLd("rst chain1", ldCyc);
      checkOutput("rst chain1 zero", aes_text_in, 128'h0);
      waitAck("rst chain1", which, ackCyc);
      checkOutput("rst chain1 who", which, 1);
      req1 = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/or1200_aes_arbiter.md
OR1200_AES_ARBITER -- requirements
Module: or1200_aes_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd63: max cycles waited for aes_done before abort.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: key_valid  in  1  AES key loaded, grants allowed.
REQ-004 SHALL have ports: req0/req1  in  1  pad request per requester (0 = load path, 1 = store path), level, held until ack.
REQ-005 SHALL have ports: seed0/seed1  in  128  fresh seed per requester; chain0/chain1  in  1  use own last pad as input (OFB step) instead of seed.
REQ-006 SHALL have ports: ack0/ack1  out  1  one-cycle completion pulse; pad_out  out  128  result, valid while either ack high; err  out  1  timeout flag, valid with ack.
REQ-007 SHALL have ports: aes_ld  out  1  AES start pulse; aes_text_in  out  128  AES input; aes_done  in  1  AES finished; aes_text_out  in  128  AES output.
REQ-008 SHALL have ports: busy  out  1  high in any state but IDLE.

Function
REQ-009 SHALL implement FSM IDLE, LOAD, WAIT, RESP.
- IDLE->LOAD when key_valid and (req0|req1); grant latched.
- LOAD->WAIT unconditionally; WAIT->RESP on aes_done or timeout; RESP->IDLE unconditionally.
REQ-010 SHALL arbitrate round-robin: single request wins; both high -> the requester not granted last; after reset requester 0 has priority.
REQ-011 SHALL assert aes_ld for exactly one cycle, in LOAD only; aes_text_in = granted chain ? granted chain register : granted seed, held stable LOAD through WAIT.
REQ-012 SHALL sample seed/chain at the IDLE->LOAD edge; later changes are ignored until the next grant.
REQ-013 SHALL on aes_done in WAIT capture aes_text_out into pad_out register and into the granted requester's 128-bit chain register.
REQ-014 SHALL ignore aes_done outside WAIT.
REQ-015 SHALL count cycles in WAIT (8-bit, cleared in LOAD); count == TIMEOUT without aes_done -> RESP with err=1, pad_out=0, chain register unchanged.
REQ-016 SHALL in RESP pulse ack of the granted requester only, for one cycle; err=0 on normal completion.
REQ-017 SHALL give latency: req high in IDLE cycle t -> aes_ld at t+1 -> ack at (aes_done cycle)+1; min 3 cycles request-to-ack (aes_done at t+2 -> ack at t+3).
REQ-018 SHALL not re-grant the just-acked requester in the ack cycle; a still-high req is re-arbitrated in IDLE on the following cycle.
REQ-019 SHALL not grant while key_valid=0; key_valid falling mid-operation does not abort.
REQ-020 SHALL complete a request whose req dropped after grant; chain register is updated, ack still pulses.
REQ-021 SHALL hold ack0 and ack1 never high simultaneously; pad_out holds last value outside RESP.

Reset
REQ-022 SHALL on rst: state IDLE, last-grant = 1 (so requester 0 wins first), timeout counter 0, chain registers 0, pad_out 0, ack0/ack1/err/aes_ld/busy 0.
REQ-023 SHALL on rst during LOAD/WAIT abandon the operation without ack; a later stray aes_done is ignored per REQ-014.

Structure
REQ-024 SHALL place state encodings and TIMEOUT default in shared package or1200_aes_arb_pkg (defines file).
REQ-025 SHALL implement arbitration as sub-module or1200_rr_arb2 (2-way round-robin, combinational grant + registered last-grant); no other sub-modules.

Verification
REQ-026 Single req0, seed0=128'h1, chain0=0, AES model done 11 cycles after aes_ld with out=128'hA5.. -> aes_text_in=128'h1, ack0 once, pad_out=128'hA5.., ack1 never.
REQ-027 req0 and req1 high together after reset -> grant order 0,1,0,1 over four completions; busy low exactly one cycle between each.
REQ-028 req1 with chain1=1 after a prior req1 producing 128'hBEEF -> aes_text_in=128'hBEEF.
REQ-029 AES model never asserts done, TIMEOUT=63 -> ack with err=1, pad_out=0 on the 64th WAIT cycle; next request proceeds normally.
REQ-030 key_valid=0 with req0 high for 20 cycles -> no aes_ld; key_valid rises -> aes_ld next cycle.
REQ-031 rst pulsed 3 cycles into WAIT, aes_done arrives afterwards -> no ack, state IDLE, chain registers 0.
